// File: rtl/tmds_encoder_3ch.sv
// tmds_encoder_3ch: three-channel TMDS 8b/10b encoder, two-stage pipeline with per-channel running disparity.
// Define TMDS_ENC_DISP_MON_EN to expose the disparity counters and a sticky out-of-range flag.
module tmds_encoder_3ch #(
  parameter int DISP_W         = 5,
  parameter bit BLANK_CLR_DISP = 1'b1
) (
  input  logic       i_pixel_clk,
  input  logic       i_pixel_rst,
  input  logic       i_de,
  input  logic       i_hsync,
  input  logic       i_vsync,
  input  logic [7:0] i_pixel_r,
  input  logic [7:0] i_pixel_g,
  input  logic [7:0] i_pixel_b,
  output logic [9:0] o_tmds_r,
  output logic [9:0] o_tmds_g,
  output logic [9:0] o_tmds_b,
  output logic       o_de
`ifdef TMDS_ENC_DISP_MON_EN
  ,
  output logic signed [DISP_W-1:0] o_disp_r,
  output logic signed [DISP_W-1:0] o_disp_g,
  output logic signed [DISP_W-1:0] o_disp_b,
  output logic                     o_disp_err
`endif
);
  localparam logic signed [DISP_W-1:0] ZR = '0;
  logic [7:0] d [3];
  logic [9:0] sym_o [3];
  logic de_q, hs_q, vs_q;
  assign d[0] = i_pixel_b;
  assign d[1] = i_pixel_g;
  assign d[2] = i_pixel_r;
  assign o_tmds_b = sym_o[0];
  assign o_tmds_g = sym_o[1];
  assign o_tmds_r = sym_o[2];
`ifdef TMDS_ENC_DISP_MON_EN
  localparam logic signed [DISP_W-1:0] PK = DISP_W'(8);
  localparam logic signed [DISP_W-1:0] NK = -PK;
  logic signed [DISP_W-1:0] cnt_o [3];
  logic oor;
  assign o_disp_b = cnt_o[0];
  assign o_disp_g = cnt_o[1];
  assign o_disp_r = cnt_o[2];
  assign oor = cnt_o[0] > PK || cnt_o[0] < NK || cnt_o[1] > PK || cnt_o[1] < NK ||
               cnt_o[2] > PK || cnt_o[2] < NK;
`endif
  always_ff @(posedge i_pixel_clk or negedge i_pixel_rst)
    if (!i_pixel_rst) begin
      de_q <= 1'b0;
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      o_de <= 1'b0;
`ifdef TMDS_ENC_DISP_MON_EN
      o_disp_err <= 1'b0;
`endif
    end else begin
      de_q <= i_de;
      hs_q <= i_hsync;
      vs_q <= i_vsync;
      o_de <= de_q;
`ifdef TMDS_ENC_DISP_MON_EN
      o_disp_err <= o_disp_err | oor;
`endif
    end
  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [3:0] n1, n1q;
    logic xnor_sel, q8, case_a, case_b;
    logic [8:0] qm_c, q_m;
    logic [1:0] ctl;
    logic [9:0] sym, sym_nxt;
    logic signed [DISP_W-1:0] cnt, cnt_nxt, bal;
    always_comb begin
      n1 = 4'($countones(d[c]));
      xnor_sel = n1 > 4'd4 || (n1 == 4'd4 && !d[c][0]);
      qm_c = {!xnor_sel, 7'b0, d[c][0]};
      for (int i = 1; i < 8; i++)
        qm_c[i] = xnor_sel ? ~(qm_c[i-1] ^ d[c][i]) : qm_c[i-1] ^ d[c][i];
    end
    // bal is the signed ones-minus-zeros balance of the 8 data bits
    always_comb begin
      q8 = q_m[8];
      n1q = 4'($countones(q_m[7:0]));
      bal = DISP_W'({n1q, 1'b0}) - DISP_W'(8);
      case_a = cnt == ZR || bal == ZR;
      case_b = (cnt > ZR && bal > ZR) || (cnt < ZR && bal < ZR);
      ctl = (c == 0) ? {vs_q, hs_q} : 2'b00;
      sym_nxt = !de_q ? (ctl == 2'd0 ? 10'h354 : ctl == 2'd1 ? 10'h0AB : ctl == 2'd2 ? 10'h154 : 10'h2AB) :
                case_a ? {!q8, q8, q8 ? q_m[7:0] : ~q_m[7:0]} :
                case_b ? {1'b1, q8, ~q_m[7:0]} : {1'b0, q8, q_m[7:0]};
      cnt_nxt = !de_q ? (BLANK_CLR_DISP ? ZR : cnt) :
                case_a ? (q8 ? cnt + bal : cnt - bal) :
                case_b ? cnt + DISP_W'({q8, 1'b0}) - bal : cnt + bal - DISP_W'({!q8, 1'b0});
    end
    always_ff @(posedge i_pixel_clk or negedge i_pixel_rst)
      if (!i_pixel_rst) begin
        q_m <= '0;
        sym <= 10'h354;
        cnt <= ZR;
      end else begin
        q_m <= qm_c;
        sym <= sym_nxt;
        cnt <= cnt_nxt;
      end
    assign sym_o[c] = sym;
`ifdef TMDS_ENC_DISP_MON_EN
    assign cnt_o[c] = cnt;
`endif
  end
endmodule

// File: tb/tb_tmds_encoder_3ch.sv
// tb_tmds_encoder_3ch: random and directed stimulus scored against an arithmetic TMDS model.
module tb_tmds_encoder_3ch;
  localparam int DW = 5;
  localparam bit CLR = 1'b1;
  logic clk = 1'b0, run = 1'b0, rst_n = 1'b1;
  logic de = 1'b0, hs = 1'b0, vs = 1'b0;
  logic [7:0] r = '0, g = '0, b = '0;
  logic [9:0] tr, tg, tb_s;
  logic ode;
`ifdef TMDS_ENC_DISP_MON_EN
  logic signed [DW-1:0] dr, dg, db;
  logic derr;
`endif
  int checks = 0, errors = 0;
  int m_cnt [3];
  logic p_de, p_hs, p_vs;
  logic [7:0] p_r, p_g, p_b;

  tmds_encoder_3ch #(.DISP_W(DW), .BLANK_CLR_DISP(CLR)) dut (
    .i_pixel_clk(clk), .i_pixel_rst(rst_n), .i_de(de), .i_hsync(hs), .i_vsync(vs),
    .i_pixel_r(r), .i_pixel_g(g), .i_pixel_b(b),
    .o_tmds_r(tr), .o_tmds_g(tg), .o_tmds_b(tb_s), .o_de(ode)
`ifdef TMDS_ENC_DISP_MON_EN
    , .o_disp_r(dr), .o_disp_g(dg), .o_disp_b(db), .o_disp_err(derr)
`endif
  );

  always #5 clk = run ? ~clk : 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int get_cnt(input int c);
`ifdef TMDS_ENC_DISP_MON_EN
    return c == 0 ? int'(db) : c == 1 ? int'(dg) : int'(dr);
`else
    return c == 0 ? int'(dut.g_ch[0].cnt) : c == 1 ? int'(dut.g_ch[1].cnt) : int'(dut.g_ch[2].cnt);
`endif
  endfunction

  // Reference: encoding computed from popcounts and integer disparity
  function automatic logic [9:0] enc(input int ch, input logic [7:0] dd, input logic den, input logic [1:0] ctl);
    int n1, ones, diff;
    logic [8:0] qm;
    bit xn;
    if (!den) begin
      if (CLR) m_cnt[ch] = 0;
      case (ctl)
        2'd0: return 10'h354;
        2'd1: return 10'h0AB;
        2'd2: return 10'h154;
        default: return 10'h2AB;
      endcase
    end
    n1 = 0;
    for (int i = 0; i < 8; i++) n1 += int'(dd[i]);
    xn = (n1 > 4) || (n1 == 4 && !dd[0]);
    qm = '0;
    qm[0] = dd[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? (qm[i-1] == dd[i]) : (qm[i-1] != dd[i]);
    qm[8] = !xn;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(qm[i]);
    diff = 2 * ones - 8;
    if (m_cnt[ch] == 0 || diff == 0) begin
      m_cnt[ch] += qm[8] ? diff : -diff;
      return {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
    end
    if ((m_cnt[ch] > 0 && diff > 0) || (m_cnt[ch] < 0 && diff < 0)) begin
      m_cnt[ch] += 2 * int'(qm[8]) - diff;
      return {1'b1, qm[8], ~qm[7:0]};
    end
    m_cnt[ch] += diff - 2 * (1 - int'(qm[8]));
    return {1'b0, qm[8], qm[7:0]};
  endfunction

  task automatic reset_model();
    for (int c = 0; c < 3; c++) m_cnt[c] = 0;
    p_de = 1'b0; p_hs = 1'b0; p_vs = 1'b0;
    p_r = '0; p_g = '0; p_b = '0;
  endtask

  task automatic check_now(input logic [9:0] eb, eg, er, input logic ed);
    chk("tmds_b", int'(tb_s), int'(eb));
    chk("tmds_g", int'(tg), int'(eg));
    chk("tmds_r", int'(tr), int'(er));
    chk("o_de", int'(ode), int'(ed));
    for (int c = 0; c < 3; c++) begin
      chk("cnt", get_cnt(c), m_cnt[c]);
      chk("disp_rng", int'(get_cnt(c) >= -8 && get_cnt(c) <= 8), 1);
    end
`ifdef TMDS_ENC_DISP_MON_EN
    chk("disp_err", int'(derr), 0);
`endif
  endtask

  task automatic cyc(input logic dd, hh, vv, input logic [7:0] rr, gg, bb);
    logic [9:0] eb, eg, er;
    logic ed;
    de = dd; hs = hh; vs = vv; r = rr; g = gg; b = bb;
    @(posedge clk);
    eb = enc(0, p_b, p_de, {p_vs, p_hs});
    eg = enc(1, p_g, p_de, 2'b00);
    er = enc(2, p_r, p_de, 2'b00);
    ed = p_de;
    p_de = dd; p_hs = hh; p_vs = vv; p_r = rr; p_g = gg; p_b = bb;
    #1 check_now(eb, eg, er, ed);
  endtask

  task automatic rnd_active(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  initial begin
    reset_model();
    #1 rst_n = 1'b0;
    #2 check_now(10'h354, 10'h354, 10'h354, 1'b0);
    run = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    chk("ctl01", int'(tb_s), 'h0AB);
    cyc(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
    chk("ctl10", int'(tb_s), 'h154);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    chk("ctl11", int'(tb_s), 'h2AB);
    chk("ctl_r", int'(tr), 'h354);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    chk("zero_sym0", int'(tb_s), 'h100);
    chk("zero_cnt0", get_cnt(0), -8);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    chk("zero_sym1", int'(tb_s), 'h3FF);
    chk("zero_cnt1", get_cnt(0), 2);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    chk("zero_sym2", int'(tb_s), 'h100);
    chk("zero_cnt2", get_cnt(0), -6);
    cyc(1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    chk("ff_sym", int'(tb_s), 'h200);
    chk("ff_cnt", get_cnt(0), -8);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    chk("blank_clr", get_cnt(0), 0);
    for (int line = 0; line < 10; line++) begin
      rnd_active(640);
      for (int i = 0; i < 20; i++) cyc(1'b0, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end
    rnd_active(100);
    #3 rst_n = 1'b0;
    reset_model();
    #1 check_now(10'h354, 10'h354, 10'h354, 1'b0);
    #2 rst_n = 1'b1;
    rnd_active(50);
    repeat (5) cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
